// File: rtl/imem_stream_fetch.sv
// Byte-addressed instruction memory for the Y86-64 fetch stage: a valid/ready byte stream loads
// programs at run time, and a registered fetch port returns a FETCH_BYTES-wide instruction window.
module imem_stream_fetch #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned FETCH_BYTES = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_start,
  input  logic [63:0]                  load_base,
  input  logic                         load_valid,
  input  logic [7:0]                   load_data,
  input  logic                         load_last,
  output logic                         load_ready,
  output logic                         load_done,
  output logic                         load_err,
  input  logic                         fetch_req,
  input  logic [63:0]                  fetch_pc,
  output logic                         fetch_ready,
  output logic                         fetch_valid,
  output logic [7:0]                   byte0,
  output logic [8*(FETCH_BYTES-1)-1:0] byte19,
  output logic                         imem_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WW = 8 * (FETCH_BYTES - 1);
  // Highest pc whose whole window fits; comparing against it avoids pc+FETCH_BYTES overflow.
  localparam logic [63:0] LastPc   = 64'(DEPTH - FETCH_BYTES);
  localparam logic [63:0] DepthPtr = 64'(DEPTH);

  typedef enum logic [0:0] {StIdle, StLoad} state_e;

  state_e      state_q, state_d;
  logic [63:0] ptr_q;
  logic        load_done_q, load_err_q;
  logic        fetch_valid_q, imem_err_q;
  logic [7:0]  byte0_q;
  logic [WW-1:0] byte19_q;

  logic [7:0] mem [DEPTH] = '{default: 8'h00};

  logic          beat, fetch_acc, start_acc, ptr_in_range, pc_oob;
  logic [WW-1:0] window;

  always_comb begin
    beat         = load_valid & load_ready;
    fetch_acc    = fetch_req & fetch_ready;
    start_acc    = load_start & (state_q == StIdle);
    ptr_in_range = ptr_q < DepthPtr;
    pc_oob       = fetch_pc > LastPc;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (load_start)         state_d = StLoad;
      StLoad: if (beat && load_last)  state_d = StIdle;
      default:                        state_d = StIdle;
    endcase
  end

  // FSM: outputs depend on state only
  always_comb begin
    load_ready  = (state_q == StLoad);
    fetch_ready = (state_q == StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      load_done_q <= beat & load_last;
      if (start_acc) begin
        ptr_q      <= load_base;
        load_err_q <= 1'b0;
      end else if (beat) begin
        ptr_q <= ptr_q + 64'd1;
        if (!ptr_in_range) load_err_q <= 1'b1;
      end
    end
  end

  // Contents survive reset; a beat coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && beat && ptr_in_range) begin
      mem[ptr_q[AW-1:0]] <= load_data;
    end
  end

  // mem[pc+1] lands in the most significant byte of the window.
  always_comb begin
    window = '0;
    for (int unsigned i = 1; i < FETCH_BYTES; i++) begin
      window[(FETCH_BYTES-1-i)*8 +: 8] = mem[fetch_pc[AW-1:0] + AW'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_valid_q <= 1'b0;
      byte0_q       <= '0;
      byte19_q      <= '0;
      imem_err_q    <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_acc;
      if (fetch_acc) begin
        if (pc_oob) begin
          byte0_q    <= '0;
          byte19_q   <= '0;
          imem_err_q <= 1'b1;
        end else begin
          byte0_q    <= mem[fetch_pc[AW-1:0]];
          byte19_q   <= window;
          imem_err_q <= 1'b0;
        end
      end
    end
  end

  assign load_done   = load_done_q;
  assign load_err    = load_err_q;
  assign fetch_valid = fetch_valid_q;
  assign byte0       = byte0_q;
  assign byte19      = byte19_q;
  assign imem_err    = imem_err_q;

endmodule

// File: doc/imem_stream_fetch.md
# imem_stream_fetch

Parametrised byte-addressed instruction memory for the Y86-64 fetch stage. It has two sides:
- A streaming load port: a valid/ready byte stream with a start address, used to write programs at run time instead of fixing them at elaboration.
- A registered fetch port: one request returns a whole instruction window (byte0 plus the next FETCH_BYTES-1 bytes) one cycle later, with an out-of-range error flag.

A two-state FSM arbitrates the two sides so a fetch never observes a partially loaded program.

## Interface
- DEPTH, 1024: memory size in bytes; valid addresses are 0..DEPTH-1.
- FETCH_BYTES, 10: instruction window size in bytes; must be at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load_start  in  1  begin a load burst; sampled only in IDLE.
- load_base  in  64  first byte address of the burst; sampled with load_start.
- load_valid  in  1  load_data holds a byte.
- load_data  in  8  byte to write.
- load_last  in  1  marks the final byte of the burst.
- load_ready  out  1  load port accepts a byte this cycle.
- load_done  out  1  one-cycle pulse after the last beat is accepted.
- load_err  out  1  sticky flag: a beat in the current burst targeted an address ≥ DEPTH.
- fetch_req  in  1  fetch request.
- fetch_pc  in  64  byte address of the instruction.
- fetch_ready  out  1  fetch side accepts a request this cycle.
- fetch_valid  out  1  byte0, byte19 and imem_err are valid this cycle.
- byte0  out  8  mem[pc].
- byte19  out  8*(FETCH_BYTES-1)  packed bytes mem[pc+1]..mem[pc+FETCH_BYTES-1]; mem[pc+1] occupies the most significant byte and mem[pc+FETCH_BYTES-1] the least significant byte.
- imem_err  out  1  the fetched window exceeds the memory bounds.

## Operation
FSM states:
- IDLE: fetch_ready=1, load_ready=0.
- LOAD: fetch_ready=0, load_ready=1.

IDLE → LOAD on load_start. The write pointer is loaded with load_base.

In LOAD, each accepted beat (load_valid & load_ready):
- If the pointer < DEPTH: write mem[ptr]=load_data.
- Otherwise: discard the byte and set load_err.
- In both cases, increment the pointer by 1 (64-bit, wraps modulo 2^64).

LOAD → IDLE on an accepted beat with load_last=1. load_done pulses on the following cycle.

load_err:
- Cleared on load_start.
- Holds its value through IDLE until the next load_start.

Fetch, accepted when fetch_req & fetch_ready:
- The bounds test is fetch_pc > DEPTH-FETCH_BYTES, evaluated in 64-bit with no overflow (do not compute pc+FETCH_BYTES).
- In range: next cycle byte0/byte19 show memory contents and imem_err=0.
- Out of range: next cycle byte0=0, byte19=0, imem_err=1.
- fetch_valid is asserted for exactly one cycle per accepted request. Back-to-back requests in consecutive IDLE cycles give back-to-back results.

Non-accepted cycles:
- fetch_valid=0.
- byte0, byte19 and imem_err hold their last values.

Simultaneous load_start and fetch_req in IDLE:
- Both are accepted.
- The fetch returns pre-load contents, because the first write occurs no earlier than the next cycle.

fetch_req in LOAD is ignored; no response is produced.

Memory contents:
- Zero at time 0.
- Not cleared by reset.

## Timing
Reset, sampled on a clock edge, forces:
- state=IDLE, write pointer=0;
- load_done=0, load_err=0, fetch_valid=0;
- byte0=0, byte19=0, imem_err=0.

Reset during LOAD:
- Aborts the burst and returns the FSM to IDLE.
- Bytes already written are kept.
- No load_done is produced.

Latencies:
- Fetch: 1 cycle, from the request edge to fetch_valid.
- load_done: 1 cycle after the last beat.
- Write visibility: a byte written at edge N is visible to a fetch accepted at edge N+1 or later.

Ready signals are functions of state only (no combinational path from inputs):
- load_ready is high throughout LOAD.
- fetch_ready is high throughout IDLE.

## Test plan
- Reset, then fetch_pc=0 → next cycle fetch_valid=1, byte0=0x00, byte19=0, imem_err=0.
- Load base 0, bytes 30 F4 0E 00 00 00 00 00 00 00 with last on the 10th beat, then fetch pc=0 → byte0=0x30, byte19=0xF40E00000000000000, load_done pulses once, load_err=0.
- Bounds: fetch pc=1014 → imem_err=0; pc=1015 → imem_err=1 with byte0=0, byte19=0; pc=0xFFFF_FFFF_FFFF_FFFF → imem_err=1.
- Load base 1022, 4 beats → mem[1022], mem[1023] written; 3rd and 4th beats dropped; load_err=1; load_done still pulses; next load_start clears load_err.
- In IDLE, assert load_start and fetch_req in the same cycle with mem[0]=0x30 and load_base=0, first beat 0x60 → fetch returns 0x30. During LOAD, fetch_req produces no fetch_valid. After the burst completes, a fetch returns 0x60.
- Reset asserted mid-burst after 3 of 6 beats → FSM in IDLE, fetch_ready=1, the 3 written bytes are retained, no load_done.
